// File: rtl/fp32_div_normalize.sv
// Normalise/round/pack stage behind the iterative FP32 fraction divider.
// Optional macro FP_DIV_DENORM_EN enables gradual underflow; otherwise tiny results flush to zero.
module fp32_div_normalize #(
  parameter int BIAS = 127,
  parameter int QW   = 26
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          sign_i,
  input  logic [9:0]    exp_i,
  input  logic [QW-1:0] quot_i,
  input  logic          sticky_i,
  input  logic [1:0]    special_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   result_o,
  output logic [2:0]    flags_o
);

  localparam logic signed [9:0] EXP_INF = 10'(2*BIAS+1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
`ifdef FP_DIV_DENORM_EN
    ST_DENORM,
`endif
    ST_ROUND,
    ST_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [QW-1:0]      m_q, m_d;
  logic signed [9:0]  e_q, e_d;
  logic               s_q, s_d;
  logic               st_q, st_d;
  logic               tiny_q, tiny_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        res_q, res_d;
  logic [2:0]         flags_q, flags_d;

  logic               rnd_g, rnd_s, rnd_inc, rnd_inexact;
  logic [24:0]        rnd_sum;
  logic [23:0]        rnd_mant;
  logic signed [9:0]  rnd_e;
  logic [31:0]        rnd_res;
  logic [2:0]         rnd_flags;
`ifdef FP_DIV_DENORM_EN
  logic signed [9:0]  dn_e;
  logic [QW-1:0]      dn_m;
`endif

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = res_q;
  assign flags_o     = flags_q;

  // Round-to-nearest-even on the top 24 bits; a mantissa carry renormalises to 1.0 and bumps e.
  always_comb begin
    rnd_g       = m_q[QW-25];
    rnd_s       = (|m_q[QW-26:0]) | st_q;
    rnd_inc     = rnd_g & (rnd_s | m_q[QW-24]);
    rnd_sum     = {1'b0, m_q[QW-1 -: 24]} + {24'h0, rnd_inc};
    rnd_mant    = rnd_sum[23:0];
    rnd_e       = e_q;
    rnd_inexact = rnd_g | rnd_s;
    if (rnd_sum[24]) begin
      rnd_mant = 24'h80_0000;
      rnd_e    = e_q + 10'sd1;
    end
    if (rnd_e >= EXP_INF) begin
      rnd_res   = {s_q, 8'hFF, 23'h0};
      rnd_flags = 3'b101;
    end else begin
      rnd_res   = {s_q, (rnd_mant[23] ? rnd_e[7:0] : 8'h00), rnd_mant[22:0]};
      rnd_flags = {1'b0, tiny_q & rnd_inexact, rnd_inexact};
    end
  end

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    s_d         = s_q;
    st_d        = st_q;
    tiny_d      = tiny_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
`ifdef FP_DIV_DENORM_EN
    dn_e        = e_q + 10'sd1;
    dn_m        = m_q >> 1;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          m_d    = quot_i;
          e_d    = $signed(exp_i);
          s_d    = sign_i;
          st_d   = sticky_i;
          tiny_d = 1'b0;
          if (special_i != 2'b00) begin
            flags_d     = 3'b000;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
            unique case (special_i)
              2'b01:   res_d = {sign_i, 31'h0};
              2'b10:   res_d = {sign_i, 8'hFF, 23'h0};
              default: res_d = 32'h7FC0_0000;
            endcase
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (m_q == '0) begin
          res_d       = {s_q, 31'h0};
          flags_d     = 3'b000;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else if (!m_q[QW-1]) begin
          m_d = m_q << 1;
          e_d = e_q - 10'sd1;
        end else if (e_q < 10'sd1) begin
`ifdef FP_DIV_DENORM_EN
          tiny_d  = 1'b1;
          state_d = ST_DENORM;
`else
          res_d       = {s_q, 31'h0};
          flags_d     = 3'b011;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
`endif
        end else begin
          state_d = ST_ROUND;
        end
      end
`ifdef FP_DIV_DENORM_EN
      // One right shift per cycle; leave as soon as the shift lands on e==1 or the mantissa empties.
      ST_DENORM: begin
        m_d  = dn_m;
        st_d = st_q | m_q[0];
        e_d  = dn_e;
        if (dn_e >= 10'sd1 || dn_m == '0) state_d = ST_ROUND;
      end
`endif
      ST_ROUND: begin
        res_d       = rnd_res;
        flags_d     = rnd_flags;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      m_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      st_q        <= 1'b0;
      tiny_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      st_q        <= st_d;
      tiny_q      <= tiny_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp32_div_normalize.sv
// Randomised + directed bench for fp32_div_normalize against an arithmetic reference model.
module tb_fp32_div_normalize;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        in_valid_i = 1'b0, sign_i = 1'b0, sticky_i = 1'b0, out_ready_i = 1'b0;
  logic [9:0]  exp_i = '0;
  logic [25:0] quot_i = '0;
  logic [1:0]  special_i = '0;
  logic        in_ready_o, out_valid_o;
  logic [31:0] result_o;
  logic [2:0]  flags_o;
  int          n_vec = 0, n_err = 0;

  always #5 clk_i = ~clk_i;

  fp32_div_normalize #(.BIAS(127), .QW(26)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .quot_i(quot_i), .sticky_i(sticky_i), .special_i(special_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .flags_o(flags_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Value-level model: normalise, optional denormal shift, RNE on the exact remainder, pack.
  task automatic model(input bit s, input int e_in, input logic [25:0] q, input bit st,
                       input logic [1:0] sp, output logic [31:0] res, output logic [2:0] fl,
                       output int lat);
    longint mm, mant, r;
    int     e, n, d;
    bit     stk, tiny, flush, inc, inexact;
    logic [7:0] ef;
`ifdef FP_DIV_DENORM_EN
    int sh;
`endif
    fl = 3'b000;
    if (sp != 2'b00) begin
      res = (sp == 2'b01) ? {s, 31'h0} : (sp == 2'b10) ? {s, 8'hFF, 23'h0} : 32'h7FC0_0000;
      lat = 1;
    end else if (q == 0) begin
      res = {s, 31'h0};
      lat = -1;
    end else begin
      mm = longint'(q); n = 0;
      while (mm < 64'h200_0000) begin mm = mm * 2; n++; end
      e = e_in - n; stk = st; tiny = 0; flush = 0; d = 0;
      if (e < 1) begin
`ifdef FP_DIV_DENORM_EN
        tiny = 1; sh = 1 - e; d = (sh > 26) ? 26 : sh;
        if (sh >= 26) begin stk = stk | (mm != 0); mm = 0; end
        else begin stk = stk | ((mm % (64'd1 << sh)) != 0); mm = mm >> sh; end
        e = 1;
`else
        flush = 1;
`endif
      end
      if (flush) begin
        res = {s, 31'h0}; fl = 3'b011; lat = -1;
      end else begin
        mant = mm / 4; r = mm % 4;
        inc = (r > 2) || (r == 2 && (stk || (mant % 2 == 1)));
        mant = mant + longint'(inc);
        if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e++; end
        inexact = (r != 0) || stk;
        if (e >= 255) begin
          res = {s, 8'hFF, 23'h0}; fl = 3'b101;
        end else begin
          ef  = (mant >= (64'd1 << 23)) ? e[7:0] : 8'h00;
          res = {s, ef, mant[22:0]};
          fl  = {1'b0, tiny & inexact, inexact};
        end
        lat = 3 + n + d;
      end
    end
  endtask

  // One transaction; exp_lat < 0 skips the latency check. hold = cycles with out_ready low.
  task automatic send(input bit s, input int e, input logic [25:0] q, input bit st,
                      input logic [1:0] sp, input logic [31:0] exp_res, input logic [2:0] exp_fl,
                      input int exp_lat, input int hold);
    int lat;
    @(negedge clk_i);
    chk("in_ready", in_ready_o, 1);
    sign_i = s; exp_i = 10'(e); quot_i = q; sticky_i = st; special_i = sp; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 200) begin @(negedge clk_i); lat++; end
    if (!out_valid_o) chk("timeout", out_valid_o, 1);
    chk("result", result_o, exp_res);
    chk("flags", flags_o, exp_fl);
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    repeat (hold) begin
      @(negedge clk_i);
      chk("hold_result", result_o, exp_res);
      chk("hold_valid", out_valid_o, 1);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("drain_valid", out_valid_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mres, rnd;
    logic [2:0]  mfl;
    int          mlat, seen, e, k;
    logic [25:0] q;
    logic [1:0]  sp;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_flags", flags_o, 3'b000);

    send(0, 127, 26'h300_0000, 0, 2'b00, 32'h3FC0_0000, 3'b000, 3, 1);
    send(0, 127, 26'h155_5555, 1, 2'b00, 32'h3F2A_AAAB, 3'b001, 4, 0);
    send(0, 300, 26'h200_0000, 0, 2'b00, 32'h7F80_0000, 3'b101, 3, 0);
    send(1, 300, 26'h200_0000, 0, 2'b00, 32'hFF80_0000, 3'b101, 3, 0);
    send(0, 127, 26'h3FF_FFFF, 0, 2'b00, 32'h4000_0000, 3'b001, 3, 0);
    send(0, 127, 26'h200_0002, 0, 2'b00, 32'h3F80_0000, 3'b001, 3, 0);
    send(1, 5,   26'h200_0000, 0, 2'b01, 32'h8000_0000, 3'b000, 1, 0);
    send(0, 5,   26'h200_0000, 1, 2'b10, 32'h7F80_0000, 3'b000, 1, 0);
`ifdef FP_DIV_DENORM_EN
    send(0, -3,  26'h200_0000, 0, 2'b00, 32'h0008_0000, 3'b000, 7, 0);
`else
    send(0, -3,  26'h200_0000, 0, 2'b00, 32'h0000_0000, 3'b011, -1, 0);
`endif

    // NaN held for 5 cycles while a second request is presented and must be ignored.
    @(negedge clk_i);
    sign_i = 1; special_i = 2'b11; exp_i = 10'd1; quot_i = 26'h1; in_valid_i = 1'b1;
    @(negedge clk_i);
    chk("nan_valid", out_valid_o, 1);
    special_i = 2'b01;
    repeat (5) begin
      chk("nan_result", result_o, 32'h7FC0_0000);
      chk("nan_flags", flags_o, 3'b000);
      chk("nan_in_ready", in_ready_o, 0);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    seen = 0;
    repeat (4) begin if (out_valid_o) seen++; @(negedge clk_i); end
    chk("nan_second_ignored", seen, 0);

    // Reset in the middle of a long normalisation.
    sign_i = 0; special_i = 2'b00; exp_i = 10'd127; quot_i = 26'h1; sticky_i = 0; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_in_ready", in_ready_o, 1);
    chk("midrst_out_valid", out_valid_o, 0);
    seen = 0;
    repeat (40) begin @(negedge clk_i); if (out_valid_o) seen++; end
    chk("midrst_no_output", seen, 0);
    send(0, 127, 26'h300_0000, 0, 2'b00, 32'h3FC0_0000, 3'b000, 3, 0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      e = (k == 0) ? $urandom_range(0, 40) - 30 :
          (k == 1) ? $urandom_range(230, 260) : $urandom_range(0, 600) - 200;
      rnd = $urandom;
      q = rnd[25:0] >> $urandom_range(0, 26);
      sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rnd = $urandom;
      model(rnd[0], e, q, rnd[1], sp, mres, mfl, mlat);
      send(rnd[0], e, q, rnd[1], sp, mres, mfl, mlat, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
